// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator arbiter slice.
package calc_pkg;

    localparam int unsigned CALC_OPND_W = 32;
    localparam int unsigned CALC_RES_W  = 33;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        DIV = 3'd4
    } calc_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StCapt,
        StResp
    } calc_arb_state_e;

    // Operations the calculator answers with zero instead of real arithmetic.
    function automatic logic calc_op_err(input logic [2:0] op,
                                         input logic [CALC_OPND_W-1:0] b);
        return (op == DIV && b == '0) || op == NOP || op > DIV;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_valid
);

    always_comb begin
        int unsigned idx;
        gnt       = '0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
        if (any_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin sharing of one registered calculator between NUM_REQ requesters.
// Define CALC_ARB_ERR_EN to add the rsp_err output flagging null/div-by-zero operations.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset_high,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][CALC_OPND_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][CALC_OPND_W-1:0]  req_b,
    input  logic [NUM_REQ-1:0][2:0]              req_opcode,
    output logic [CALC_OPND_W-1:0]               calc_a,
    output logic [CALC_OPND_W-1:0]               calc_b,
    output logic [2:0]                           calc_opcode,
    input  logic [CALC_RES_W-1:0]                calc_result,
    output logic                                 rsp_valid,
`ifdef CALC_ARB_ERR_EN
    output logic                                 rsp_err,
`endif
    input  logic                                 rsp_ready,
    output logic [ID_W-1:0]                      rsp_id,
    output logic [CALC_RES_W-1:0]                rsp_result
);

    calc_arb_state_e         state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CALC_OPND_W-1:0]  calc_a_q, calc_a_d;
    logic [CALC_OPND_W-1:0]  calc_b_q, calc_b_d;
    logic [2:0]              calc_op_q, calc_op_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic [CALC_RES_W-1:0]   rsp_result_q, rsp_result_d;
    logic                    rsp_valid_q, rsp_valid_d;
`ifdef CALC_ARB_ERR_EN
    logic                    err_q, err_d;
`endif

    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic                    any_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        calc_a_d     = calc_a_q;
        calc_b_d     = calc_b_q;
        calc_op_d    = calc_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
`ifdef CALC_ARB_ERR_EN
        err_d        = err_q;
`endif
        case (state_q)
            StIdle: begin
                // Never advertise a grant while reset is discarding state.
                if (any_valid && !reset_high) begin
                    req_ready = gnt;
                    calc_a_d  = req_a[gnt_idx];
                    calc_b_d  = req_b[gnt_idx];
                    calc_op_d = req_opcode[gnt_idx];
                    rsp_id_d  = gnt_idx;
                    rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifdef CALC_ARB_ERR_EN
                    err_d     = calc_op_err(req_opcode[gnt_idx], req_b[gnt_idx]);
`endif
                    state_d   = StExec;
                end
            end
            StExec: begin
                state_d = StCapt;
            end
            StCapt: begin
                rsp_result_d = calc_result;
                rsp_valid_d  = 1'b1;
                calc_op_d    = NOP;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_high) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            calc_a_q     <= '0;
            calc_b_q     <= '0;
            calc_op_q    <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 1'b0;
`ifdef CALC_ARB_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            calc_a_q     <= calc_a_d;
            calc_b_q     <= calc_b_d;
            calc_op_q    <= calc_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef CALC_ARB_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    assign calc_a      = calc_a_q;
    assign calc_b      = calc_b_q;
    assign calc_opcode = calc_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
`ifdef CALC_ARB_ERR_EN
    assign rsp_err     = rsp_valid_q & err_q;
`endif

endmodule
